// File: rtl/fir_window_loader.sv
// Polyphase FIR input loader: keeps a shared column history and, on every accepted column,
// writes a ROWS x TAPS sliding window into the phase bank selected for that column.
module fir_window_loader #(
  parameter int DATA_W = 24,
  parameter int ROWS   = 3,
  parameter int TAPS   = 3,
  parameter int PHASES = 3,
  localparam int PH_W  = (PHASES > 1) ? $clog2(PHASES) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clear,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [ROWS*DATA_W-1:0]              in_data,
  input  logic                                stall,
  input  logic                                ext_phase_en,
  input  logic [PH_W-1:0]                     ext_phase,
  output logic                                out_valid,
  output logic [PH_W-1:0]                     out_phase,
  output logic [PHASES-1:0]                   win_valid,
  output logic [PHASES*ROWS*TAPS*DATA_W-1:0]  win_flat
);

  localparam int FILL_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int HIST_N = (TAPS > 1) ? TAPS - 1 : 1;
  localparam int COL_W  = ROWS * DATA_W;
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(PHASES - 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(TAPS - 1);

  // With TAPS == 1 a single dummy history entry exists but is never read.
  logic [COL_W-1:0]  hist [HIST_N];
  logic [COL_W-1:0]  col  [TAPS];
  logic [PH_W-1:0]   pc;
  logic [PH_W-1:0]   ph;
  logic [PH_W-1:0]   pc_next;
  logic [FILL_W-1:0] fill;
  logic              accept;

  assign in_ready = ~stall & ~clear;
  assign accept   = in_valid & in_ready;

  always_comb begin
    ph = pc;
    if (ext_phase_en)
      ph = ({1'b0, ext_phase} >= (PH_W+1)'(PHASES)) ? PH_LAST : ext_phase;
    pc_next = (ph == PH_LAST) ? '0 : ph + PH_W'(1);
  end

  // Window columns oldest to newest; the incoming column is always the newest one.
  always_comb begin
    for (int c = 0; c < TAPS - 1; c++)
      col[c] = hist[c];
    col[TAPS-1] = in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= '0;
      fill      <= '0;
      win_valid <= '0;
      win_flat  <= '0;
      out_valid <= 1'b0;
      out_phase <= '0;
      for (int j = 0; j < HIST_N; j++)
        hist[j] <= '0;
    end else if (clear) begin
      pc        <= '0;
      fill      <= '0;
      win_valid <= '0;
      win_flat  <= '0;
      out_valid <= 1'b0;
      out_phase <= '0;
      for (int j = 0; j < HIST_N; j++)
        hist[j] <= '0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        out_phase     <= ph;
        pc            <= pc_next;
        win_valid[ph] <= (fill == FILL_LAST);
        if (fill != FILL_LAST)
          fill <= fill + FILL_W'(1);
        for (int j = 0; j < HIST_N - 1; j++)
          hist[j] <= hist[j+1];
        hist[HIST_N-1] <= in_data;
        for (int p = 0; p < PHASES; p++)
          if (PH_W'(p) == ph)
            for (int r = 0; r < ROWS; r++)
              for (int c = 0; c < TAPS; c++)
                win_flat[((p*ROWS + r)*TAPS + c)*DATA_W +: DATA_W] <= col[c][r*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_fir_window_loader.sv
// Scoreboard bench for fir_window_loader: a default 3x3x3 instance plus a PHASES=4, TAPS=2 variant,
// each checked against a sample-history model of the expected windows.
module tb_fir_window_loader;

  typedef logic [647:0] word_t;
  typedef struct {
    logic [1:0] ph;
    word_t      flat;
    logic [3:0] wv;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic         clear, in_valid, stall, ext_phase_en, in_ready, out_valid;
  logic [1:0]   ext_phase, out_phase;
  logic [71:0]  in_data;
  logic [2:0]   win_valid;
  logic [647:0] win_flat;

  logic         v_clear, v_in_valid, v_stall, v_ext_phase_en, v_in_ready, v_out_valid;
  logic [1:0]   v_ext_phase, v_out_phase;
  logic [71:0]  v_in_data;
  logic [3:0]   v_win_valid;
  logic [575:0] v_win_flat;

  fir_window_loader #(.DATA_W(24), .ROWS(3), .TAPS(3), .PHASES(3)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .stall(stall), .ext_phase_en(ext_phase_en), .ext_phase(ext_phase),
    .out_valid(out_valid), .out_phase(out_phase), .win_valid(win_valid), .win_flat(win_flat)
  );

  fir_window_loader #(.DATA_W(24), .ROWS(3), .TAPS(2), .PHASES(4)) dut_v (
    .clk(clk), .rst(rst), .clear(v_clear), .in_valid(v_in_valid), .in_ready(v_in_ready),
    .in_data(v_in_data), .stall(v_stall), .ext_phase_en(v_ext_phase_en), .ext_phase(v_ext_phase),
    .out_valid(v_out_valid), .out_phase(v_out_phase), .win_valid(v_win_valid), .win_flat(v_win_flat)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic checkOutput(input string tag, input word_t got, input word_t want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Model: samples accepted since the last reset/clear, and the banks they produced.
  int         m_bank [2][4][3][3];
  int         m_samp [2][64];
  int         m_cnt  [2];
  int         m_pc   [2];
  logic [3:0] m_wv   [2];
  exp_t       q0[$];
  exp_t       q1[$];
  exp_t       e0, e1;

  function automatic int nph(input int inst);
    return (inst == 0) ? 3 : 4;
  endfunction

  function automatic int ntap(input int inst);
    return (inst == 0) ? 3 : 2;
  endfunction

  function automatic logic [71:0] sample(input int k);
    return {24'(16*k + 2), 24'(16*k + 1), 24'(16*k)};
  endfunction

  function automatic word_t build(input int inst);
    word_t res = '0;
    int t = ntap(inst);
    for (int p = 0; p < nph(inst); p++)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < t; c++)
          res[((p*3 + r)*t + c)*24 +: 24] = 24'(m_bank[inst][p][r][c]);
    return res;
  endfunction

  // Row r of bank p, oldest column in the most significant position.
  function automatic word_t rowOf(input word_t f, input int p, input int r, input int t);
    word_t res = '0;
    for (int c = 0; c < t; c++)
      res = (res << 24) | word_t'(f[((p*3 + r)*t + c)*24 +: 24]);
    return res;
  endfunction

  task automatic modelReset(input int inst, input bit drop_queue);
    for (int p = 0; p < 4; p++)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          m_bank[inst][p][r][c] = 0;
    m_cnt[inst] = 0;
    m_pc[inst]  = 0;
    m_wv[inst]  = '0;
    if (drop_queue) begin
      if (inst == 0) q0.delete();
      else q1.delete();
    end
  endtask

  task automatic applyStimulus(input int inst, input int k, input logic en, input logic [1:0] eph);
    int p, t, ph, idx;
    bit will_accept;
    exp_t e;
    p = nph(inst);
    t = ntap(inst);
    if (inst == 0) begin
      in_valid = 1'b1; in_data = sample(k); ext_phase_en = en; ext_phase = eph;
      will_accept = !stall && !clear;
    end else begin
      v_in_valid = 1'b1; v_in_data = sample(k); v_ext_phase_en = en; v_ext_phase = eph;
      will_accept = !v_stall && !v_clear;
    end
    if (will_accept) begin
      ph = en ? ((int'(eph) >= p) ? p - 1 : int'(eph)) : m_pc[inst];
      m_samp[inst][m_cnt[inst]] = k;
      m_cnt[inst]++;
      for (int c = 0; c < t; c++) begin
        idx = m_cnt[inst] - 1 - (t - 1 - c);
        for (int r = 0; r < 3; r++)
          m_bank[inst][ph][r][c] = (idx >= 0) ? 16*m_samp[inst][idx] + r : 0;
      end
      m_wv[inst][ph] = (m_cnt[inst] >= t);
      m_pc[inst] = (ph + 1) % p;
      e.ph   = 2'(ph);
      e.flat = build(inst);
      e.wv   = m_wv[inst];
      if (inst == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    v_in_valid = 1'b0;
    @(negedge clk);
  endtask

  // Each output pulse is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1) begin
      if (q0.size() == 0) checkOutput("unexpected_out_valid", word_t'(1), word_t'(0));
      else begin
        e0 = q0.pop_front();
        checkOutput("out_phase", word_t'(out_phase), word_t'(e0.ph));
        checkOutput("win_flat", win_flat, e0.flat);
        checkOutput("win_valid", word_t'(win_valid), word_t'(e0.wv));
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && v_out_valid === 1'b1) begin
      if (q1.size() == 0) checkOutput("v_unexpected_out_valid", word_t'(1), word_t'(0));
      else begin
        e1 = q1.pop_front();
        checkOutput("v_out_phase", word_t'(v_out_phase), word_t'(e1.ph));
        checkOutput("v_win_flat", word_t'(v_win_flat), e1.flat);
        checkOutput("v_win_valid", word_t'(v_win_valid), word_t'(e1.wv));
      end
    end
  end

  word_t snap;

  initial begin
    rst = 1'b1;
    clear = 1'b0; in_valid = 1'b0; in_data = '0; stall = 1'b0; ext_phase_en = 1'b0; ext_phase = '0;
    v_clear = 1'b0; v_in_valid = 1'b0; v_in_data = '0; v_stall = 1'b0; v_ext_phase_en = 1'b0; v_ext_phase = '0;
    modelReset(0, 1'b1);
    modelReset(1, 1'b1);
    @(negedge clk);
    checkOutput("rst_win_flat", win_flat, '0);
    checkOutput("rst_win_valid", word_t'(win_valid), '0);
    checkOutput("rst_out_valid", word_t'(out_valid), '0);
    checkOutput("rst_out_phase", word_t'(out_phase), '0);
    checkOutput("rst_in_ready", word_t'(in_ready), word_t'(1));
    rst = 1'b0;

    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, k, 1'b0, 2'd0);
      if (k == 2) begin
        checkOutput("k2_win_valid", word_t'(win_valid), word_t'(3'b100));
        checkOutput("k2_bank2_row0", rowOf(win_flat, 2, 0, 3), word_t'({24'd0, 24'd16, 24'd32}));
        checkOutput("k2_out_phase", word_t'(out_phase), word_t'(2));
      end
    end
    checkOutput("k5_win_valid", word_t'(win_valid), word_t'(3'b111));
    checkOutput("k5_bank2_row1", rowOf(win_flat, 2, 1, 3), word_t'({24'd49, 24'd65, 24'd81}));
    checkOutput("k5_bank0_row2", rowOf(win_flat, 0, 2, 3), word_t'({24'd18, 24'd34, 24'd50}));

    stall = 1'b1; in_valid = 1'b1; in_data = sample(6);
    snap = win_flat;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("stall_in_ready", word_t'(in_ready), '0);
      checkOutput("stall_out_valid", word_t'(out_valid), '0);
      checkOutput("stall_win_flat", win_flat, snap);
    end
    stall = 1'b0;
    applyStimulus(0, 6, 1'b0, 2'd0);
    checkOutput("unstall_out_phase", word_t'(out_phase), word_t'(0));
    checkOutput("unstall_bank0_row0", rowOf(win_flat, 0, 0, 3), word_t'({24'd64, 24'd80, 24'd96}));

    applyStimulus(0, 7, 1'b1, 2'd3);
    checkOutput("legacy_out_phase", word_t'(out_phase), word_t'(2));
    checkOutput("legacy_bank2_row0", rowOf(win_flat, 2, 0, 3), word_t'({24'd80, 24'd96, 24'd112}));
    applyStimulus(0, 8, 1'b0, 2'd0);
    checkOutput("legacy_back_phase", word_t'(out_phase), word_t'(0));
    idle();

    for (int k = 0; k < 4; k++)
      applyStimulus(0, k, 1'b0, 2'd0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_win_flat", win_flat, '0);
    checkOutput("arst_win_valid", word_t'(win_valid), '0);
    checkOutput("arst_out_valid", word_t'(out_valid), '0);
    modelReset(0, 1'b1);
    modelReset(1, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 5; k++)
      applyStimulus(0, k, 1'b0, 2'd0);
    clear = 1'b1; in_valid = 1'b1; in_data = sample(5);
    #1 checkOutput("clear_in_ready", word_t'(in_ready), '0);
    modelReset(0, 1'b0);
    @(negedge clk);
    clear = 1'b0;
    checkOutput("clear_win_flat", win_flat, '0);
    checkOutput("clear_win_valid", word_t'(win_valid), '0);
    checkOutput("clear_out_valid", word_t'(out_valid), '0);
    checkOutput("clear_out_phase", word_t'(out_phase), '0);
    applyStimulus(0, 5, 1'b0, 2'd0);
    checkOutput("postclr_bank0_row0", rowOf(win_flat, 0, 0, 3), word_t'({24'd0, 24'd0, 24'd80}));
    checkOutput("postclr_wv1", word_t'(win_valid), '0);
    applyStimulus(0, 6, 1'b0, 2'd0);
    checkOutput("postclr_wv2", word_t'(win_valid), '0);
    applyStimulus(0, 7, 1'b0, 2'd0);
    checkOutput("postclr_wv3", word_t'(win_valid), word_t'(3'b100));
    idle();

    for (int k = 0; k < 9; k++) begin
      applyStimulus(1, k, 1'b0, 2'd0);
      if (k == 3) checkOutput("v_wrap_phase", word_t'(v_out_phase), word_t'(3));
    end
    checkOutput("v_final_wv", word_t'(v_win_valid), word_t'(4'b1111));
    checkOutput("v_final_phase", word_t'(v_out_phase), word_t'(0));
    checkOutput("v_bank0_row0", rowOf(word_t'(v_win_flat), 0, 0, 2), word_t'({24'd112, 24'd128}));
    idle();
    idle();
    checkOutput("sb_drain", word_t'(q0.size() + q1.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
